// File: rtl/stream_msg_encryptor_pkg.sv
// Shared types and byte cipher helpers for the message encryptor and its
// matching decryptor.
package enc_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Carry out of bit 7 is dropped, so encryption is addition mod 256.
    function automatic byte_t enc_byte(input byte_t p, input byte_t k);
        return p + k;
    endfunction

    function automatic byte_t dec_byte(input byte_t c, input byte_t k);
        return c - k;
    endfunction

endpackage

// File: rtl/stream_msg_encryptor_key_regfile.sv
// SEC_LEN-byte key store: one gated write port, one asynchronous read port.
module key_regfile
    import enc_pkg::*;
#(
    parameter  int unsigned SEC_LEN = 3,
    localparam int unsigned KIDX_W  = $clog2(SEC_LEN > 1 ? SEC_LEN : 2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [KIDX_W-1:0] i_waddr,
    input  byte_t             i_wdata,
    input  logic [KIDX_W-1:0] i_raddr,
    output byte_t             o_rdata
);

    byte_t r_key [0:SEC_LEN-1];
    logic  w_addr_ok;

    // One extra bit so SEC_LEN itself is representable when it is a power of two.
    assign w_addr_ok = ({1'b0, i_waddr} < (KIDX_W + 1)'(SEC_LEN));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SEC_LEN; i++) begin
                r_key[i] <= '0;
            end
        end else if (i_we && w_addr_ok) begin
            r_key[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_key[i_raddr];

endmodule

// File: rtl/stream_msg_encryptor.sv
// Byte-stream encryptor: adds a repeating key to each plaintext byte and
// presents MSG_LEN cipher bytes as one registered array.
module stream_msg_encryptor
    import enc_pkg::*;
#(
    parameter  int unsigned MSG_LEN = 10,
    parameter  int unsigned SEC_LEN = 3,
    localparam int unsigned IDX_W   = $clog2(MSG_LEN > 1 ? MSG_LEN : 2),
    localparam int unsigned KIDX_W  = $clog2(SEC_LEN > 1 ? SEC_LEN : 2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_we,
    input  logic [KIDX_W-1:0] key_addr,
    input  byte_t             key_data,
    input  logic              in_valid,
    input  byte_t             in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output byte_t             text_out [0:MSG_LEN-1],
    output logic              busy
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_pos;
    logic [KIDX_W-1:0]  r_kidx;
    byte_t              r_buf [0:MSG_LEN-1];

    logic               w_accept;
    logic               w_last;
    logic               w_key_we;
    logic [KIDX_W-1:0]  w_kidx_inc;
    byte_t              w_key;

    assign w_accept = in_valid && (r_state == FILL);
    assign w_last   = (r_pos == IDX_W'(MSG_LEN - 1));
    // Key may only change at a message boundary so one message never mixes keys.
    assign w_key_we = key_we && (r_state == FILL) && (r_pos == '0);

    key_regfile #(
        .SEC_LEN (SEC_LEN)
    ) u_key_regfile (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_key_we),
        .i_waddr (key_addr),
        .i_wdata (key_data),
        .i_raddr (r_kidx),
        .o_rdata (w_key)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            FILL: begin
                in_ready = 1'b1;
                if (w_accept && w_last) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = FILL;
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    always_comb begin
        w_kidx_inc = r_kidx + 1'b1;
        if (r_kidx == KIDX_W'(SEC_LEN - 1)) begin
            w_kidx_inc = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pos  <= '0;
            r_kidx <= '0;
            for (int unsigned i = 0; i < MSG_LEN; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_accept) begin
            r_buf[r_pos] <= enc_byte(in_data, w_key);
            if (w_last) begin
                r_pos  <= '0;
                r_kidx <= '0;
            end else begin
                r_pos  <= r_pos + 1'b1;
                r_kidx <= w_kidx_inc;
            end
        end
    end

    assign busy     = (r_state == HOLD) || (r_pos != '0);
    assign text_out = r_buf;

endmodule

// File: tb/tb_stream_msg_encryptor.sv
// Randomised scoreboard bench for stream_msg_encryptor with directed test-plan cases.
module tb_stream_msg_encryptor;
    import enc_pkg::*;

    localparam int unsigned MSG_LEN = 10;
    localparam int unsigned SEC_LEN = 3;
    localparam int unsigned KIDX_W  = 2;

    typedef byte_t msg_t [MSG_LEN];

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              key_we = 1'b0;
    logic [KIDX_W-1:0] key_addr = '0;
    byte_t             key_data = '0;
    logic              in_valid = 1'b0;
    byte_t             in_data = '0;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    byte_t             text_out [0:MSG_LEN-1];
    logic              busy;

    logic rand_ready = 1'b0;
    logic rnd_ready  = 1'b0;
    logic man_ready  = 1'b0;

    int checks   = 0;
    int failures = 0;

    // Reference model state: key, cipher bytes of the message in progress,
    // completed messages awaiting the consumer.
    byte_t mkey [SEC_LEN];
    byte_t cq [$];
    msg_t  expq [$];
    logic  held    = 1'b0;
    logic  started = 1'b0;

    always #5 clk = ~clk;

    assign out_ready = rand_ready ? rnd_ready : man_ready;

    stream_msg_encryptor #(
        .MSG_LEN (MSG_LEN),
        .SEC_LEN (SEC_LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_we    (key_we),
        .key_addr  (key_addr),
        .key_data  (key_data),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .text_out  (text_out),
        .busy      (busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            rnd_ready = 1'($urandom_range(0, 1));
        end
    end

    // Behavioural model, advanced on each rising edge from the bench's own inputs.
    initial begin
        forever begin
            int    n0;
            logic  was_held;
            byte_t c;
            msg_t  m;
            @(posedge clk);
            if (rst) begin
                for (int k = 0; k < int'(SEC_LEN); k++) mkey[k] = '0;
                cq.delete();
                expq.delete();
                held    = 1'b0;
                started = 1'b1;
            end else begin
                n0       = cq.size();
                was_held = held;
                if (in_valid && !was_held) begin
                    c = byte_t'((int'(in_data) + int'(mkey[n0 % int'(SEC_LEN)])) % 256);
                    cq.push_back(c);
                    if (cq.size() == int'(MSG_LEN)) begin
                        for (int k = 0; k < int'(MSG_LEN); k++) m[k] = cq[k];
                        expq.push_back(m);
                        cq.delete();
                        held = 1'b1;
                    end
                end
                if (key_we && !was_held && n0 == 0 && int'(key_addr) < int'(SEC_LEN))
                    mkey[key_addr] = key_data;
                if (was_held && out_ready)
                    held = 1'b0;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (started) begin
                chk("out_valid", int'(out_valid), int'(held));
                chk("in_ready", int'(in_ready), int'(!held));
                chk("busy", int'(busy), int'(held || cq.size() != 0));
                if (out_valid) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_message", 1, 0);
                    end else begin
                        for (int k = 0; k < int'(MSG_LEN); k++)
                            chk($sformatf("text_out[%0d]", k), int'(text_out[k]), int'(expq[0][k]));
                        if (out_ready) void'(expq.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic write_key(input int a, input int d);
        key_we   = 1'b1;
        key_addr = KIDX_W'(a);
        key_data = byte_t'(d);
        @(negedge clk);
        key_we = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
    endtask

    task automatic send_byte(input byte_t b);
        in_valid = 1'b1;
        in_data  = b;
        wait_ready();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(out_valid), 1);
    endtask

    task automatic release_msg();
        man_ready = 1'b1;
        @(negedge clk);
        man_ready = 1'b0;
    endtask

    initial begin
        string s;
        byte_t hw_exp [MSG_LEN];
        byte_t kw [SEC_LEN];
        byte_t wrap_pat [3];
        int    n;

        s      = "HelloWorld";
        hw_exp = '{8'd147, 8'd170, 8'd197, 8'd183, 8'd180, 8'd176, 8'd186, 8'd183, 8'd197, 8'd175};
        kw     = '{8'd75, 8'd69, 8'd89};
        wrap_pat = '{8'd100, 8'd7, 8'd1};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < int'(MSG_LEN); k++)
            chk("reset_text_out", int'(text_out[k]), 0);

        // Key load, basic encryption, latency, round trip, backpressure.
        for (int k = 0; k < int'(SEC_LEN); k++) write_key(k, int'(kw[k]));
        for (int k = 0; k < int'(MSG_LEN); k++) send_byte(s[k]);
        chk("latency_out_valid", int'(out_valid), 1);
        for (int k = 0; k < int'(MSG_LEN); k++) begin
            chk("hello_cipher", int'(text_out[k]), int'(hw_exp[k]));
            chk("round_trip", int'(dec_byte(text_out[k], kw[k % int'(SEC_LEN)])), int'(s[k]));
        end
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (5) begin
            @(negedge clk);
            chk("hold_in_ready", int'(in_ready), 0);
            chk("hold_stable", int'(text_out[0]), int'(hw_exp[0]));
        end
        release_msg();
        chk("bubble_in_ready", int'(in_ready), 1);
        send_byte(8'h55);
        for (int k = 1; k < int'(MSG_LEN); k++) send_byte(byte_t'($urandom));
        wait_valid("bp_valid");
        chk("bp_kidx0", int'(text_out[0]), (8'h55 + 75) % 256);
        release_msg();

        // Illegal key writes: mid-message and out-of-range address.
        write_key(3, 9);
        for (int k = 0; k < 4; k++) send_byte(s[k]);
        write_key(0, 1);
        write_key(3, 9);
        for (int k = 4; k < int'(MSG_LEN); k++) send_byte(s[k]);
        wait_valid("illegal_valid");
        for (int k = 0; k < int'(MSG_LEN); k++)
            chk("illegal_key_cipher", int'(text_out[k]), int'(hw_exp[k]));
        release_msg();

        // Byte wrap.
        write_key(0, 200);
        write_key(1, 0);
        write_key(2, 255);
        for (int k = 0; k < int'(MSG_LEN); k++) send_byte(wrap_pat[k % 3]);
        wait_valid("wrap_valid");
        chk("wrap0", int'(text_out[0]), 44);
        chk("wrap1", int'(text_out[1]), 7);
        chk("wrap2", int'(text_out[2]), 0);
        chk("wrap3", int'(text_out[3]), 44);
        release_msg();

        // Randomised traffic with random consumer stalls and key writes.
        rand_ready = 1'b1;
        for (int m = 0; m < 15; m++) begin
            for (int k = 0; k < int'(MSG_LEN); k++) begin
                if ($urandom_range(0, 3) == 0) @(negedge clk);
                if ($urandom_range(0, 5) == 0) begin
                    key_we   = 1'b1;
                    key_addr = KIDX_W'($urandom_range(0, 3));
                    key_data = byte_t'($urandom);
                end
                send_byte(byte_t'($urandom));
                key_we = 1'b0;
            end
        end
        n = 0;
        while ((expq.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("random_drain", expq.size(), 0);
        rand_ready = 1'b0;
        man_ready  = 1'b0;
        @(negedge clk);

        // Reset mid-message.
        for (int k = 0; k < 6; k++) send_byte(byte_t'($urandom));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        for (int k = 0; k < int'(MSG_LEN); k++) send_byte(8'd65);
        wait_valid("rst_valid");
        for (int k = 0; k < int'(MSG_LEN); k++)
            chk("rst_zero_key", int'(text_out[k]), 65);
        release_msg();

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_msg_encryptor.md
Name: stream_msg_encryptor

Overview:
- Upstream stage of the combinational decryptor: accepts plaintext one byte per handshake and encrypts it with a repeating SEC_LEN-byte key.
- Encryption rule: cipher[i] = (plain[i] + key[i mod SEC_LEN]) mod 256.
- Buffers MSG_LEN cipher bytes, then presents them as one array on text_out, which is wired directly to the decryptor's text_in.
- The key is held in a register file that is loaded between messages.

Parameters:
- MSG_LEN, 10, bytes per message; must be >= 1.
- SEC_LEN, 3, key length in bytes; must be >= 1.
- IDX_W, $clog2(MSG_LEN>1?MSG_LEN:2), width of the byte position counter; derived, do not override.
- KIDX_W, $clog2(SEC_LEN>1?SEC_LEN:2), width of the key index and key_addr; derived, do not override.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset, synchronous and active-high.
- key_we  in  1  key register write strobe.
- key_addr  in  KIDX_W  key byte index; values >= SEC_LEN are ignored.
- key_data  in  8  key byte to write.
- in_valid  in  1  plaintext byte valid.
- in_data  in  8  plaintext byte.
- in_ready  out  1  stage can accept a plaintext byte.
- out_valid  out  1  text_out holds a complete encrypted message.
- out_ready  in  1  consumer accepts the message.
- text_out  out  [7:0] x [0:MSG_LEN-1]  encrypted message, unpacked array, same shape as the decryptor's text_in.
- busy  out  1  high while a message is partially filled (pos != 0) or held.

Behaviour:
- Reset (synchronous, active-high), applied at the next clk edge:
  - state=FILL, pos=0, kidx=0, out_valid=0, in_ready=1, busy=0.
  - All text_out bytes = 0; all key bytes = 0 (the identity cipher).
- Reset asserted mid-message or in HOLD discards the partial or held message; no out_valid pulse results.
- States:
  - FILL: in_ready=1.
    - Accept when in_valid&&in_ready.
    - On accept: buffer[pos] <= in_data + key[kidx] (8-bit wrap, carry dropped).
    - Then pos++ and kidx++; kidx wraps SEC_LEN-1 -> 0.
    - On accepting byte pos==MSG_LEN-1: pos <= 0, kidx <= 0, go to HOLD.
  - HOLD: in_ready=0, out_valid=1, text_out stable.
    - On out_ready: go to FILL, out_valid <= 0.
- Handshake rules:
  - Latency from the last byte accepted to out_valid=1 is exactly 1 cycle.
  - No input is accepted in the cycle out_ready is seen; in_ready returns the following cycle (one-cycle bubble per message).
- The key index restarts at 0 for every message; the key stream never carries over between messages.
- Key writes:
  - Honoured only when state==FILL && pos==0 && key_addr < SEC_LEN.
  - Otherwise ignored, with no error flag.
  - A key write and a plaintext accept in the same cycle: the first byte uses the OLD key[0]; the new value applies from the next cycle.
- text_out is a registered buffer. While in FILL, bytes not yet overwritten keep their previous contents; consumers must qualify with out_valid.
- All outputs are registered or decoded from state only; no combinational path from any input to any output.

Decomposition:
- Package enc_pkg:
  - typedef byte_t (logic [7:0]).
  - enum state_t {FILL, HOLD}.
  - Function enc_byte(byte_t p, byte_t k) returning p+k mod 256, shared with the decryptor's inverse dec_byte(c,k) = c-k.
- Sub-module key_regfile holds SEC_LEN bytes.
  - One write port gated by the rules above.
  - One asynchronous read by kidx.

Test Plan:
- Key load and basic encryption:
  - Stimulus: rst 2 cycles; write key "KEY" (75,69,89); stream "HelloWorld" with in_valid held high.
  - Required: out_valid rises 1 cycle after the 10th accept; text_out = 147,170,197,183,180,176,186,183,197,175.
- Round trip: wire text_out to the decryptor and apply the same key -> the decryptor's output reads "HelloWorld".
- Byte wrap:
  - Stimulus: key {200,0,255}; plaintext 100,7,1 repeated to 10 bytes.
  - Required: text_out[0]=44, [1]=7, [2]=0, [3]=44; no carry bleeds into the next byte.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles after out_valid.
  - Required: text_out stable, in_ready=0, in_valid bytes are not consumed.
  - Stimulus: pulse out_ready.
  - Required: next message starts at kidx=0 after one bubble cycle.
- Illegal key write:
  - Stimulus: key_we at pos=4 with key_addr=0, data=1; also key_we with key_addr=3.
  - Required: both ignored; the key stays "KEY" and the message is unchanged.
- Reset mid-message:
  - Stimulus: assert rst after 6 accepts.
  - Required: next cycle pos=0, out_valid=0, key=0; then 10 bytes of 'A' give text_out all 65.
